memory_reader: RTL
==================

# memory_reader

Read-side engine for the team's single-clock word memory: it drives the memory's read port (address, read strobe, registered read data) and streams a burst of consecutive words out over a valid/ready interface. It complements the write path that fills the memory. The block issues one read per cycle when buffer space allows, so it sustains one word per cycle under no backpressure and never drops a word under backpressure.

## Interface
- DATA_WIDTH, 64, word width in bits
- ADDR_WIDTH, 3, memory address width; memory depth is 2**ADDR_WIDTH words
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous active-low reset; deasserts synchronously to clk externally
- start  input  1  burst request; sampled only in IDLE
- startAddr  input  ADDR_WIDTH  first word address, captured with start
- burstLen  input  ADDR_WIDTH+1  number of words, captured with start; 0 allowed
- busy  output  1  high while a burst is in progress
- done  output  1  one-cycle pulse at burst completion
- addrOut  output  ADDR_WIDTH  memory read address, registered
- RD  output  1  memory read strobe, registered
- dataOut  input  DATA_WIDTH  memory read data, valid the cycle after the edge that sampled RD=1
- outData  output  DATA_WIDTH  streamed word, head of the output FIFO
- outValid  output  1  outData valid
- outReady  input  1  consumer accept; a transfer happens on an edge where outValid && outReady
- outLast  output  1  present only with MEMORY_READER_LAST_EN

## Operation
- The FSM has the states IDLE, READ, DRAIN, and DONE.
- IDLE: when start=1, the block loads the address counter from startAddr and the remaining count from burstLen. If burstLen=0 it goes to DONE. Otherwise it goes to READ.
- READ: it issues a read (RD=1, addrOut=address) when occupancy + in-flight < 4. On each issue, the address increments modulo 2**ADDR_WIDTH (7 wraps to 0 for the default width) and the remaining count decrements. When the last read issues, it goes to DRAIN.
- DRAIN: it waits until in-flight = 0 and the FIFO is empty (the last word has been transferred), then goes to DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
- Output buffer: a 4-entry FIFO. Each read result enters it 2 edges after the edge that registered RD=1 (one edge for the memory, one for capture). The in-flight count tracks issued reads whose data has not yet entered the FIFO, and is at most 2.
- A push and a pop in the same cycle leave the occupancy unchanged. The issue check uses the occupancy before the pop, so it is pessimistic, and overflow is impossible.
- busy is high in READ, DRAIN and DONE, and low in IDLE.
- start is ignored while busy. burstLen above the memory depth re-reads wrapped addresses in order.
- Reset: rst_n=0 forces IDLE asynchronously and clears all state. busy=0, done=0, RD=0, addrOut=0, outValid=0, outData=0, and outLast=0 if present. In-flight data is discarded.

## Timing
- start sampled at edge E0:
  - RD=1 and addrOut=startAddr during cycle E0–E1.
  - Memory data is on dataOut after E1.
  - The word is captured at E2, so outValid=1 after E2.
- First-word latency is 2 cycles from the start edge.
- Throughput is one word per cycle while outReady stays high.
- done rises on the edge after the final transfer edge, and busy falls one cycle later.
- When outReady=0, outValid and outData hold stable until the transfer. Issue stalls once occupancy + in-flight reaches 4.
- RD is never asserted in IDLE or DRAIN.

## Configuration
- MEMORY_READER_LAST_EN:
  - When defined, the outLast port exists. It is high together with outValid on the final word of the burst, and stored as a FIFO sideband bit.
  - When undefined, the port and its logic are absent. All other behaviour is identical.

## Test plan
- Memory preloaded with word[i]=i+0x10. start, startAddr=2, burstLen=4, outReady=1 -> outData sequence 0x12, 0x13, 0x14, 0x15 on consecutive cycles, the first 2 cycles after start. done pulses once, and busy=0 afterwards.
- startAddr=6, burstLen=4 -> addrOut sequence 6, 7, 0, 1, and outData 0x16, 0x17, 0x10, 0x11.
- burstLen=8 with outReady toggling 1,0,0,1 -> all 8 words in order with no loss or duplication. RD stalls when occupancy + in-flight = 4. outData is stable while stalled.
- burstLen=0 -> no RD, no outValid. done pulses one cycle after start.
- rst_n pulled low mid-burst after 3 words -> outputs reset immediately. A new burst (startAddr=0, burstLen=2) then returns 0x10, 0x11 only.
- start pulsed again while busy -> ignored, and the original burst completes. With MEMORY_READER_LAST_EN, outLast=1 only on the final word.

Source files
------------

// File: rtl/memory_reader.sv
// memory_reader: burst read engine for the single-clock word memory.
// Issues up to one read per cycle into a registered-output memory and
// streams the returned words through a 4-entry FIFO over valid/ready.
// Optional feature macro: MEMORY_READER_LAST_EN adds the outLast port,
// carried as a FIFO sideband bit marking the final word of the burst.
module memory_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  input  logic [ADDR_WIDTH:0]   burstLen,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addrOut,
  output logic                  RD,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady
`ifdef MEMORY_READER_LAST_EN
  ,
  output logic                  outLast
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | issuing reads while FIFO space (occupancy + in-flight) allows
  // DRAIN | all reads issued, waiting for the pipeline and FIFO to empty
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ONE = 1;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     remain_q;
  logic                    rd_q;
  logic [ADDR_WIDTH-1:0]   raddr_q;
  logic                    mvld_q;
  logic [DATA_WIDTH-1:0]   fifo_q [4];
  logic [1:0]              wptr_q;
  logic [1:0]              rptr_q;
  logic [2:0]              cnt_q;
  logic [2:0]              cnt_d;
  logic [2:0]              pending;
  logic                    push;
  logic                    pop;
  logic                    can_issue;
`ifdef MEMORY_READER_LAST_EN
  logic                    rlast_q;
  logic                    mlast_q;
  logic [3:0]              flast_q;
`endif

  // FIFO bookkeeping and the (pre-pop, hence pessimistic) issue check
  always_comb begin
    push      = mvld_q;
    pop       = (cnt_q != 3'd0) && outReady;
    pending   = cnt_q + {2'b00, rd_q} + {2'b00, mvld_q};
    can_issue = pending < 3'd4;
    cnt_d     = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 3'd1;
    else if (!push && pop) cnt_d = cnt_q - 3'd1;
  end

  // Burst FSM; RD/addrOut registered so the first read goes out in the cycle after start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      rd_q     <= 1'b0;
      raddr_q  <= '0;
`ifdef MEMORY_READER_LAST_EN
      rlast_q  <= 1'b0;
`endif
    end else begin
      rd_q <= 1'b0;
`ifdef MEMORY_READER_LAST_EN
      rlast_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            if (burstLen == '0) begin
              state_q <= DONE;
            end else begin
              rd_q     <= 1'b1;
              raddr_q  <= startAddr;
              addr_q   <= startAddr + A_ONE;
              remain_q <= burstLen - L_ONE;
              state_q  <= READ;
`ifdef MEMORY_READER_LAST_EN
              rlast_q  <= (burstLen == L_ONE);
`endif
            end
          end
        end
        READ: begin
          // leave one cycle after the last issue so RD is never high in DRAIN
          if (remain_q == '0) begin
            state_q <= DRAIN;
          end else if (can_issue) begin
            rd_q     <= 1'b1;
            raddr_q  <= addr_q;
            addr_q   <= addr_q + A_ONE;
            remain_q <= remain_q - L_ONE;
`ifdef MEMORY_READER_LAST_EN
            rlast_q  <= (remain_q == L_ONE);
`endif
          end
        end
        DRAIN: begin
          if (pending == 3'd0) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-data pipeline and output FIFO; data lands two edges after RD is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvld_q <= 1'b0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
`ifdef MEMORY_READER_LAST_EN
      mlast_q <= 1'b0;
      flast_q <= '0;
`endif
    end else begin
      mvld_q <= rd_q;
`ifdef MEMORY_READER_LAST_EN
      mlast_q <= rlast_q;
`endif
      if (push) begin
        fifo_q[wptr_q] <= dataOut;
`ifdef MEMORY_READER_LAST_EN
        flast_q[wptr_q] <= mlast_q;
`endif
        wptr_q <= wptr_q + 2'd1;
      end
      if (pop) rptr_q <= rptr_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign RD       = rd_q;
  assign addrOut  = raddr_q;
  assign outData  = fifo_q[rptr_q];
  assign outValid = (cnt_q != 3'd0);
`ifdef MEMORY_READER_LAST_EN
  assign outLast  = outValid && flast_q[rptr_q];
`endif

endmodule
